// File: rtl/put_arb_pkg.sv
// rtl/put_arb_pkg.sv - shared state encoding and credit counter width for the put channel arbiter
package put_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_e;

  // Wide enough for any MAX_CREDITS in 1..15.
  localparam int CREDIT_W = 4;

endpackage

// File: rtl/put_channel_arbiter_rr_picker.sv
// rtl/put_channel_arbiter_rr_picker.sv - round-robin winner search starting after the last grant
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      last_grant_i,
  output logic [GW-1:0]      winner_o,
  output logic               found_o
);

  logic [GW-1:0] idx;
  logic          hit;

  // Scan (last+1) .. (last+NUM_REQ) mod NUM_REQ; the first valid requester wins.
  always_comb begin
    hit      = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_grant_i) + k) % NUM_REQ);
      if (!hit && req_i[idx]) begin
        hit      = 1'b1;
        winner_o = idx;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/put_channel_arbiter.sv
// rtl/put_channel_arbiter.sv - credit-gated packet arbiter; PUT_CHANNEL_ARBITER_STATS_EN adds packet counters
module put_channel_arbiter
  import put_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int MAX_CREDITS = 4,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  input  logic                      credit_ret,
  output logic [GW-1:0]             grant_id,
  output logic                      busy
`ifdef PUT_CHANNEL_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_pkts,
  output logic                      stat_credit_err
`endif
);

  localparam logic [CREDIT_W-1:0] MAX_CR     = CREDIT_W'(MAX_CREDITS);
  localparam logic [GW-1:0]       LAST_RESET = GW'(NUM_REQ - 1);

  state_e                          state_q, state_d;
  logic [GW-1:0]                   grant_q, grant_d;
  logic [GW-1:0]                   last_grant_q, last_grant_d;
  logic [CREDIT_W-1:0]             credits_q, credits_d;
  logic [GW-1:0]                   pick_winner;
  logic                            pick_found;
  logic                            has_credit;
  logic                            xfer_beat;
  logic [NUM_REQ-1:0][DATA_W-1:0]  data_v;

  assign data_v     = req_data;
  assign has_credit = (credits_q != '0);
  assign xfer_beat  = out_valid & out_ready;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .winner_o     (pick_winner),
    .found_o      (pick_found)
  );

  // Consumer-side outputs: only the granted requester is visible, and only in XFER.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    if (state_q == XFER) begin
      out_valid          = req_valid[grant_q] & has_credit;
      out_data           = data_v[grant_q];
      out_last           = req_last[grant_q];
      req_ready[grant_q] = out_ready & has_credit;
    end
  end

  // Next state: arbitrate for one cycle, then hold the grant until the last beat leaves.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: if (|req_valid) state_d = ARB;
      ARB: begin
        if (pick_found) begin
          grant_d = pick_winner;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (xfer_beat && out_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credits: a beat consumes one slot, a return restores one; both together cancel out.
  always_comb begin
    credits_d = credits_q;
    if (xfer_beat && !credit_ret) begin
      credits_d = credits_q - CREDIT_W'(1);
    end else if (credit_ret && !xfer_beat && credits_q != MAX_CR) begin
      credits_d = credits_q + CREDIT_W'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RESET;
      credits_q    <= MAX_CR;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      credits_q    <= credits_d;
    end
  end

`ifdef PUT_CHANNEL_ARBITER_STATS_EN
  logic [NUM_REQ-1:0][15:0] pkts_q;
  logic                     credit_err_q;
  logic                     credit_ovf;

  // A return that arrives with every slot already free is a consumer protocol error.
  assign credit_ovf      = credit_ret && (credits_q == MAX_CR) && !xfer_beat;
  assign stat_pkts       = pkts_q;
  assign stat_credit_err = credit_err_q;

  // Wrapping per-requester packet counts and the sticky credit error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkts_q       <= '0;
      credit_err_q <= 1'b0;
    end else begin
      if (credit_ovf) credit_err_q <= 1'b1;
      if (xfer_beat && out_last) pkts_q[grant_q] <= pkts_q[grant_q] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_put_channel_arbiter.sv
// tb/tb_put_channel_arbiter.sv - scoreboard bench for put_channel_arbiter
module tb_put_channel_arbiter;

  typedef struct packed {
    logic [1:0]  gid;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat2_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0]       req_valid, req_last, req_ready;
  logic [3:0][31:0] rd;
  logic [127:0]     req_data;
  logic             out_valid, out_last, out_ready, credit_ret, busy;
  logic [31:0]      out_data;
  logic [1:0]       grant_id;

  logic [1:0]       b_req_valid, b_req_last, b_req_ready;
  logic [1:0][7:0]  b_rd;
  logic [15:0]      b_req_data;
  logic             b_out_valid, b_out_last, b_out_ready, b_credit_ret, b_busy;
  logic [7:0]       b_out_data;
  logic             b_grant_id;

  assign req_data   = rd;
  assign b_req_data = b_rd;

`ifdef PUT_CHANNEL_ARBITER_STATS_EN
  logic [63:0] stat_pkts;
  logic        stat_credit_err;
  logic [31:0] b_stat_pkts;
  logic        b_stat_credit_err;
`endif

  put_channel_arbiter #(.NUM_REQ(4), .DATA_W(32), .MAX_CREDITS(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .credit_ret(credit_ret), .grant_id(grant_id), .busy(busy)
`ifdef PUT_CHANNEL_ARBITER_STATS_EN
    , .stat_pkts(stat_pkts), .stat_credit_err(stat_credit_err)
`endif
  );

  put_channel_arbiter #(.NUM_REQ(2), .DATA_W(8), .MAX_CREDITS(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data), .req_last(b_req_last),
    .req_ready(b_req_ready), .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
    .out_ready(b_out_ready), .credit_ret(b_credit_ret), .grant_id(b_grant_id), .busy(b_busy)
`ifdef PUT_CHANNEL_ARBITER_STATS_EN
    , .stat_pkts(b_stat_pkts), .stat_credit_err(b_stat_credit_err)
`endif
  );

  int     total = 0;
  int     bad = 0;
  int     nbeats = 0;
  int     nbeats2 = 0;
  int     cyc = 0;
  int     gap_prev = -1;
  bit     gap_on = 1'b0;
  beat_t  exp_q[$];
  beat2_t q2[$];
  beat_t  e;
  beat2_t e2;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_unexpected: got data %0h expected no beat", out_data);
      end else begin
        e = exp_q.pop_front();
        check("beat_gid", 32'(grant_id), 32'(e.gid));
        check("beat_data", out_data, e.data);
        check("beat_last", 32'(out_last), 32'(e.last));
      end
      if (gap_on) begin
        if (gap_prev >= 0) check("pkt_gap", cyc - gap_prev, 3);
        gap_prev = cyc;
      end
      nbeats++;
    end
    if (b_out_valid && b_out_ready) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat2_unexpected: got data %0h expected no beat", b_out_data);
      end else begin
        e2 = q2.pop_front();
        check("beat2_data", 32'(b_out_data), 32'(e2.data));
        check("beat2_last", 32'(b_out_last), 32'(e2.last));
      end
      nbeats2++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive(input logic [1:0] r, input logic [31:0] d, input logic l);
    req_valid[r] = 1'b1;
    rd[r]        = d;
    req_last[r]  = l;
    exp_q.push_back('{gid: r, data: d, last: l});
  endtask

  task automatic wait_acc(input logic [1:0] r);
    int n = 0;
    @(negedge clk);
    while (!req_ready[r] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[r]) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: requester %0d got ready=0 expected ready=1", r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc2();
    int n = 0;
    @(negedge clk);
    while (!b_req_ready[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_req_ready[1]) begin
      total++;
      bad++;
      $display("FAIL accept2_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] r, input int n, input logic [31:0] base, input int ret_beat);
    for (int b = 0; b < n; b++) begin
      drive(r, base + 32'(b), (b == n - 1));
      credit_ret = (b == ret_beat);
      wait_acc(r);
      credit_ret = 1'b0;
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    int          target;
    int          n;
    logic [7:0]  bd;
    rst = 1'b1;
    req_valid = '0; req_last = '0; rd = '0; out_ready = 1'b1; credit_ret = 1'b0;
    b_req_valid = '0; b_req_last = '0; b_rd = '0; b_out_ready = 1'b1; b_credit_ret = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_credits", 32'(dut.credits_q), 4);
    check("rst_busy2", 32'(b_busy), 0);

    // Single requester 2, 3-beat packet
    @(posedge clk); #1;
    send(2'd2, 3, 32'h2000_0000, -1);
    @(negedge clk);
    check("t1_credits", 32'(dut.credits_q), 1);
    check("t1_busy", 32'(busy), 0);
    check("t1_grant", 32'(grant_id), 2);

    // All four requesters continuously valid with 1-beat packets
    do_reset();
    for (int i = 0; i < 4; i++) rd[i] = 32'hA000_0000 | 32'(i);
    exp_q.push_back('{gid: 2'd0, data: 32'hA000_0000, last: 1'b1});
    exp_q.push_back('{gid: 2'd1, data: 32'hA000_0001, last: 1'b1});
    exp_q.push_back('{gid: 2'd2, data: 32'hA000_0002, last: 1'b1});
    exp_q.push_back('{gid: 2'd3, data: 32'hA000_0003, last: 1'b1});
    exp_q.push_back('{gid: 2'd0, data: 32'hA000_0000, last: 1'b1});
    target = nbeats + 5;
    gap_on = 1'b1; gap_prev = -1;
    req_last = 4'hF; req_valid = 4'hF; credit_ret = 1'b1;
    n = 0;
    while (nbeats < target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = '0; req_last = '0; credit_ret = 1'b0; gap_on = 1'b0;
    check("t2_beats", nbeats, target);
    @(negedge clk);
    check("t2_credits", 32'(dut.credits_q), 4);

    // Credit return at max is ignored; transfer plus return at credits=1 holds
    do_reset();
    @(posedge clk); #1 credit_ret = 1'b1;
    @(posedge clk); #1 credit_ret = 1'b0;
    @(negedge clk);
    check("t3_credits_sat", 32'(dut.credits_q), 4);
`ifdef PUT_CHANNEL_ARBITER_STATS_EN
    check("t3_credit_err", 32'(stat_credit_err), 1);
`endif
    @(posedge clk); #1;
    send(2'd3, 4, 32'h3000_0000, 3);
    @(negedge clk);
    check("t3_credits_hold", 32'(dut.credits_q), 1);

    // Consumer stall mid-packet while requester 1 also requests
    do_reset();
    drive(2'd0, 32'hC000_0000, 1'b0);
    wait_acc(2'd0);
    drive(2'd0, 32'hC000_0001, 1'b0);
    out_ready = 1'b0;
    req_valid[1] = 1'b1; rd[1] = 32'hD000_0001; req_last[1] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_grant", 32'(grant_id), 0);
      check("t4_data", out_data, 32'hC000_0001);
      check("t4_valid", 32'(out_valid), 1);
      check("t4_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_acc(2'd0);
    drive(2'd0, 32'hC000_0002, 1'b1);
    wait_acc(2'd0);
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    exp_q.push_back('{gid: 2'd1, data: 32'hD000_0001, last: 1'b1});
    wait_acc(2'd1);
    req_valid[1] = 1'b0; req_last[1] = 1'b0;

    // Reset on the second beat abandons the packet
    do_reset();
    drive(2'd2, 32'hE000_0000, 1'b0);
    wait_acc(2'd2);
    drive(2'd2, 32'hE000_0001, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; req_last = '0;
    @(negedge clk);
    check("t5_busy", 32'(busy), 0);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_req_ready", 32'(req_ready), 0);
    check("t5_out_last", 32'(out_last), 0);
    check("t5_out_data", out_data, 0);
    check("t5_grant", 32'(grant_id), 0);
    check("t5_credits", 32'(dut.credits_q), 4);

    // Two-credit instance: a 4-beat packet stalls after two beats
    @(posedge clk); #1;
    b_req_valid[1] = 1'b1; b_req_last[1] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bd = 8'hA0 + 8'(b);
      b_rd[1] = bd;
      q2.push_back('{data: bd, last: 1'b0});
      wait_acc2();
    end
    b_rd[1] = 8'hA2;
    q2.push_back('{data: 8'hA2, last: 1'b0});
    repeat (3) begin
      @(negedge clk);
      check("t6_stall_valid", 32'(b_out_valid), 0);
      check("t6_stall_ready", 32'(b_req_ready), 0);
      check("t6_grant", 32'(b_grant_id), 1);
    end
    check("t6_beats2", nbeats2, 2);
    @(posedge clk); #1 b_credit_ret = 1'b1;
    @(posedge clk); #1 b_credit_ret = 1'b0;
    wait_acc2();
    b_rd[1] = 8'hA3; b_req_last[1] = 1'b1;
    q2.push_back('{data: 8'hA3, last: 1'b1});
    repeat (3) begin
      @(negedge clk);
      check("t6_stall2_valid", 32'(b_out_valid), 0);
    end
    check("t6_beats3", nbeats2, 3);
    @(posedge clk); #1 b_credit_ret = 1'b1;
    @(posedge clk); #1 b_credit_ret = 1'b0;
    wait_acc2();
    b_req_valid = '0; b_req_last = '0;
    @(negedge clk);
    check("t6_busy", 32'(b_busy), 0);
    check("t6_beats4", nbeats2, 4);

    check("q_empty", exp_q.size(), 0);
    check("q2_empty", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
